// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_pkg
//  Description : Shared widths, end-of-program marker and loader state
//                encoding for the UART program loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int INSTRUCTION_LENGTH = 32;
    localparam int PC_LENGTH          = 32;
    localparam int MEM_DEPTH_DEFAULT  = 256;
    localparam int BYTES_PER_WORD     = INSTRUCTION_LENGTH / 8;

    localparam logic [INSTRUCTION_LENGTH-1:0] HALT_WORD = 32'hFFFF_FFFF;

    // Loader control states; CKSUM is only reachable when the checksum
    // trailer is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_CKSUM = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : loader_word_assembler
//  Description : Packs a big-endian byte stream into words. The first byte
//                of a word lands in the MSBs. A one-cycle word_valid pulse
//                follows the cycle in which the last byte was accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_word_assembler #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    localparam int BYTES = WORD_W / 8;
    localparam int IDX_W = $clog2(BYTES);

    // Only the leading BYTES-1 bytes need holding; the last byte goes
    // straight into the output word.
    logic [IDX_W-1:0]    byte_idx;
    logic [WORD_W-9:0]   partial;
    logic                last_byte;

    assign last_byte = (byte_idx == IDX_W'(BYTES - 1));

    // Byte index, partial-word shift register and registered word output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx   <= '0;
            partial    <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else if (clear) begin
            byte_idx   <= '0;
            partial    <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_valid && last_byte;
            if (byte_valid) begin
                if (last_byte) begin
                    byte_idx <= '0;
                    word     <= {partial, byte_data};
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
                partial <= {partial[WORD_W-17:0], byte_data};
            end
        end
    end

endmodule : loader_word_assembler
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Turns a UART byte stream into instruction words and writes
//                them to instruction memory at byte addresses 0,4,8,... while
//                the core is stalled. The core is released once the HALT word
//                has been stored.
//                Build option PROGRAM_LOADER_CHECKSUM_EN: after the HALT write
//                one more byte is expected; it must equal the XOR of every
//                program byte, otherwise the load ends in ERROR.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import mips_pkg::*;
#(
    parameter int                            INSTRUCTION_LENGTH = mips_pkg::INSTRUCTION_LENGTH,
    parameter int                            PC_LENGTH          = mips_pkg::PC_LENGTH,
    parameter int                            MEM_DEPTH          = MEM_DEPTH_DEFAULT,
    parameter logic [INSTRUCTION_LENGTH-1:0] HALT_WORD          = mips_pkg::HALT_WORD
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load_start,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            instr_wr_en,
    output logic [PC_LENGTH-1:0]            instr_wr_addr,
    output logic [INSTRUCTION_LENGTH-1:0]   instr_wr_data,
    output logic                            mips_enable,
    output logic                            load_busy,
    output logic                            load_done,
    output logic                            load_error,
    output logic [$clog2(MEM_DEPTH):0]      word_count
);

    localparam int COUNT_W = $clog2(MEM_DEPTH) + 1;

    loader_state_t                  state;
    loader_state_t                  next_state;
    logic                           accept_byte;
    logic                           word_valid;
    logic [INSTRUCTION_LENGTH-1:0]  word;
    logic                           word_in_recv;
    logic                           mem_full;
    logic                           overflow;
    logic                           halt_written;
    logic [PC_LENGTH-1:0]           write_addr;
    logic [COUNT_W-1:0]             count;

    // A byte coinciding with load_start belongs to the aborted load.
    assign accept_byte = rx_valid && (state == ST_RECV) && !load_start;

    loader_word_assembler #(
        .WORD_W     (INSTRUCTION_LENGTH)
    ) u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_start),
        .byte_valid (accept_byte),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Full is checked before any write, so the address never wraps.
    assign mem_full     = (count == COUNT_W'(MEM_DEPTH));
    assign word_in_recv = word_valid && (state == ST_RECV) && !load_start;
    assign overflow     = word_in_recv && mem_full;
    assign halt_written = instr_wr_en && (word == HALT_WORD);

    assign instr_wr_en   = word_in_recv && !mem_full;
    assign instr_wr_addr = write_addr;
    assign instr_wr_data = word;
    assign word_count    = count;

    // Write address and word count advance after each write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_addr <= '0;
            count      <= '0;
        end else if (load_start) begin
            write_addr <= '0;
            count      <= '0;
        end else if (instr_wr_en) begin
            write_addr <= write_addr + PC_LENGTH'(4);
            count      <= count + COUNT_W'(1);
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] checksum;

    // Running XOR over every program byte accepted in this load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (load_start) begin
            checksum <= '0;
        end else if (accept_byte) begin
            checksum <= checksum ^ rx_data;
        end
    end
`endif

    // Loader state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; status outputs follow the current state.
    always_comb begin
        next_state  = state;
        mips_enable = 1'b0;
        load_busy   = 1'b0;
        load_done   = 1'b0;
        load_error  = 1'b0;

        if (load_start) begin
            next_state = ST_RECV;
        end else begin
            case (state)
                ST_RECV: begin
                    if (overflow) begin
                        next_state = ST_ERROR;
                    end else if (halt_written) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        next_state = ST_CKSUM;
`else
                        next_state = ST_DONE;
`endif
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                ST_CKSUM: begin
                    if (rx_valid) begin
                        next_state = (rx_data == checksum) ? ST_DONE : ST_ERROR;
                    end
                end
`endif
                default: next_state = state;
            endcase
        end

        case (state)
            ST_RECV:  load_busy = 1'b1;
            ST_CKSUM: load_busy = 1'b1;
            ST_DONE: begin
                mips_enable = 1'b1;
                load_done   = 1'b1;
            end
            ST_ERROR: load_error = 1'b1;
            default:  load_busy = 1'b0;
        endcase
    end

endmodule : program_loader
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Self-checking bench for program_loader (memory depth 4).
//                Directed scenarios plus randomized programs, all checked
//                against a word-level model of the load protocol.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        instr_wr_en;
    logic [31:0] instr_wr_addr;
    logic [31:0] instr_wr_data;
    logic        mips_enable;
    logic        load_busy;
    logic        load_done;
    logic        load_error;
    logic [2:0]  word_count;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         got_q[$];
    logic [31:0] prog_q[$];

    program_loader #(
        .MEM_DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load_start    (load_start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .instr_wr_en   (instr_wr_en),
        .instr_wr_addr (instr_wr_addr),
        .instr_wr_data (instr_wr_data),
        .mips_enable   (mips_enable),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_error    (load_error),
        .word_count    (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (instr_wr_en === 1'b1) begin
            got_q.push_back('{addr: instr_wr_addr, data: instr_wr_data, cyc: cyc});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Hold the given inputs for exactly one clock cycle.
    task automatic drive(input logic v, input logic [7:0] d, input logic s);
        @(posedge clk);
        #1;
        rx_valid   = v;
        rx_data    = d;
        load_start = s;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wr_en"},  64'(instr_wr_en),   64'd0);
        check({tag, ".addr"},   64'(instr_wr_addr), 64'd0);
        check({tag, ".data"},   64'(instr_wr_data), 64'd0);
        check({tag, ".mips"},   64'(mips_enable),   64'd0);
        check({tag, ".busy"},   64'(load_busy),     64'd0);
        check({tag, ".done"},   64'(load_done),     64'd0);
        check({tag, ".err"},    64'(load_error),    64'd0);
        check({tag, ".count"},  64'(word_count),    64'd0);
    endtask

    // Load prog_q (one word per entry) and compare against the model:
    // words are written in order at 4*i until HALT is written or a word
    // would land at index DEPTH (overflow -> error, nothing written).
    task automatic run_program(input string tag, input int max_gap, input bit collide,
                               input logic [7:0] cks_mask);
        int          exp_n;
        int          sent_words;
        bit          exp_done;
        bit          exp_err;
        bit          halted;
        logic [7:0]  x;
        logic [31:0] wd;
        int          exp_cyc_q[$];

        exp_n      = 0;
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        halted     = 1'b0;
        x          = 8'h00;
        sent_words = prog_q.size();
        for (int i = 0; i < prog_q.size(); i++) begin
            if (i == DEPTH) begin
                exp_err    = 1'b1;
                sent_words = i + 1;
                break;
            end
            wd = prog_q[i];
            x  = x ^ wd[31:24] ^ wd[23:16] ^ wd[15:8] ^ wd[7:0];
            exp_n++;
            if (wd == HALT) begin
                halted     = 1'b1;
                exp_done   = 1'b1;
                sent_words = i + 1;
                break;
            end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (halted && cks_mask != 8'h00) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end
`endif

        got_q.delete();
        if (collide) drive(1'b1, 8'($urandom), 1'b1);
        else         drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        check({tag, ".start_mips"},  64'(mips_enable), 64'd0);
        check({tag, ".start_busy"},  64'(load_busy),   64'd1);
        check({tag, ".start_count"}, 64'(word_count),  64'd0);

        for (int w = 0; w < sent_words; w++) begin
            wd = prog_q[w];
            for (int b = 0; b < 4; b++) begin
                repeat ($urandom_range(max_gap, 0)) drive(1'b0, 8'h00, 1'b0);
                drive(1'b1, wd[31 - 8*b -: 8], 1'b0);
                if (b == 3) exp_cyc_q.push_back(cyc);
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (halted) begin
            drive(1'b1, x ^ cks_mask, 1'b0);
            drive(1'b0, 8'h00, 1'b0);
        end
`endif
        repeat (3) drive(1'b0, 8'h00, 1'b0);

        check({tag, ".nwrites"}, 64'(got_q.size()), 64'(exp_n));
        for (int i = 0; i < exp_n && i < got_q.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), 64'(got_q[i].addr), 64'(4 * i));
            check($sformatf("%s.data%0d", tag, i), 64'(got_q[i].data), 64'(prog_q[i]));
            check($sformatf("%s.cyc%0d",  tag, i), 64'(got_q[i].cyc),  64'(exp_cyc_q[i] + 1));
        end
        check({tag, ".mips"},  64'(mips_enable), 64'(exp_done));
        check({tag, ".done"},  64'(load_done),   64'(exp_done));
        check({tag, ".err"},   64'(load_error),  64'(exp_err));
        check({tag, ".busy"},  64'(load_busy),   64'(!exp_done && !exp_err));
        check({tag, ".count"}, 64'(word_count),  64'(exp_n));
        check({tag, ".wr_en"}, 64'(instr_wr_en), 64'd0);
    endtask

    function automatic logic [31:0] rand_non_halt();
        logic [31:0] w;
        w = $urandom;
        if (w == HALT) w = 32'h0000_0000;
        return w;
    endfunction

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset in the middle of a word
        got_q.delete();
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b1, 8'h5A, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("midrecv.busy", 64'(load_busy), 64'd1);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        drive(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        // Bytes outside a load are ignored
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        drive(1'b1, 8'h33, 1'b0);
        drive(1'b1, 8'h44, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        check("idle.nwrites", 64'(got_q.size()), 64'd0);
        check("idle.busy",    64'(load_busy),    64'd0);

        // Directed two-word program
        prog_q = '{32'h2001_0005, HALT};
        run_program("basic", 1, 1'b0, 8'h00);

        // Back-to-back bytes across word boundaries
        prog_q = '{rand_non_halt(), rand_non_halt(), rand_non_halt(), HALT};
        run_program("b2b", 0, 1'b0, 8'h00);

        // Restart from DONE with a byte colliding with load_start
        prog_q = '{HALT};
        run_program("restart", 0, 1'b1, 8'h00);

        // Overflow: five non-HALT words into a four-word memory
        prog_q = '{rand_non_halt(), rand_non_halt(), rand_non_halt(),
                   rand_non_halt(), rand_non_halt()};
        run_program("overflow", 1, 1'b0, 8'h00);

        // Randomized programs
        for (int it = 0; it < 24; it++) begin
            int          len;
            logic [7:0]  mask;
            prog_q.delete();
            len = $urandom_range(6, 1);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(3, 0) == 0) prog_q.push_back(HALT);
                else                           prog_q.push_back(rand_non_halt());
            end
            if ($urandom_range(1, 0) == 1) prog_q[len - 1] = HALT;
            mask = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            run_program($sformatf("rand%0d", it), $urandom_range(2, 0),
                        1'($urandom_range(3, 0) == 0), mask);
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // HALT-only program: trailer 0x00 accepted, 0x01 rejected
        prog_q = '{HALT};
        run_program("cks_good", 0, 1'b0, 8'h00);
        prog_q = '{HALT};
        run_program("cks_bad", 0, 1'b0, 8'h01);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_program_loader
`default_nettype wire
